// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : demux_pkg
//  Description : Shared types and constants for the registered 1:2
//                demultiplexer (demux_16bit_reg) and its slot sub-module.
//                  SEL_X / SEL_Y : select encodings (1 = X, 0 = Y)
//                  slot_state_t  : per-slot EMPTY/FULL state
//                  CNT_W         : width of the optional delivery counters
//  Optional    : DEMUX_CNT_EN enables the delivery counters in the users.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam logic SEL_X = 1'b1;
    localparam logic SEL_Y = 1'b0;

    localparam int CNT_W = 16;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : One-entry output register with a valid/ready handshake.
//                The slot can drain and reload in the same cycle.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                load_i       - an input word is transferred into this slot
//                data_i       - word to load
//                ready_i      - downstream consumer takes the held word
//                accept_o     - slot can take a word this cycle
//                valid_o      - slot holds a word
//                data_o       - held word (stable while valid_o is high)
//                count_o      - delivered-word counter (DEMUX_CNT_EN only)
//  Optional    : DEMUX_CNT_EN adds count_o and its counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             accept_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] count_o
`endif
);

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q;

    // A FULL slot whose consumer is ready frees its entry in this same
    // cycle, so it can accept a replacement word.
    assign accept_o = (state_q == EMPTY) || ready_i;
    assign valid_o  = (state_q == FULL);
    assign data_o   = data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load_i)             state_d = FULL;
            FULL:  if (ready_i && !load_i) state_d = EMPTY;
            default:                       state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] count_q;

    // Counts output handshakes; wraps naturally at the top of its range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (valid_o && ready_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
`endif

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_16bit_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_16bit_reg
//  Description : Registered 1:2 demultiplexer. Routes a source word to the
//                X slot (in_sel = 1) or the Y slot (in_sel = 0); each slot
//                is a one-entry register with its own valid/ready handshake
//                so the two consumers can stall independently.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                in_valid/in_ready       - source handshake
//                in_sel, in_data         - destination select and word
//                x_valid/x_ready/x_data  - X destination
//                y_valid/y_ready/y_data  - Y destination
//                x_count, y_count        - delivery counters (DEMUX_CNT_EN)
//  Optional    : DEMUX_CNT_EN adds x_count / y_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_16bit_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [WIDTH-1:0] x_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count
`endif
);

    logic w_sel_x;
    logic w_x_accept;
    logic w_y_accept;
    logic w_xfer;

    assign w_sel_x  = (in_sel == SEL_X);
    // Combinational from the consumers' ready and in_sel; driven even when
    // in_valid is low.
    assign in_ready = w_sel_x ? w_x_accept : w_y_accept;
    assign w_xfer   = in_valid && in_ready;

    demux_slot #(.WIDTH(WIDTH)) u_slot_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_xfer && w_sel_x),
        .data_i   (in_data),
        .ready_i  (x_ready),
        .accept_o (w_x_accept),
        .valid_o  (x_valid),
        .data_o   (x_data)
`ifdef DEMUX_CNT_EN
        ,
        .count_o  (x_count)
`endif
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_xfer && !w_sel_x),
        .data_i   (in_data),
        .ready_i  (y_ready),
        .accept_o (w_y_accept),
        .valid_o  (y_valid),
        .data_o   (y_data)
`ifdef DEMUX_CNT_EN
        ,
        .count_o  (y_count)
`endif
    );

endmodule : demux_16bit_reg
`default_nettype wire

// File: tb/tb_demux_16bit_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_16bit_reg
//  Description : Directed self-checking bench for demux_16bit_reg.
//  Optional    : DEMUX_CNT_EN enables the counter checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_16bit_reg;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             x_valid;
    logic             x_ready;
    logic [WIDTH-1:0] x_data;
    logic             y_valid;
    logic             y_ready;
    logic [WIDTH-1:0] y_data;
`ifdef DEMUX_CNT_EN
    logic [15:0]      x_count;
    logic [15:0]      y_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    demux_16bit_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_data   (x_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data)
`ifdef DEMUX_CNT_EN
        ,
        .x_count  (x_count),
        .y_count  (y_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int stream_err;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 16'hFFFF;
        x_ready  = 1'b0;
        y_ready  = 1'b0;

        // Reset held across edges with in_valid high: nothing loads.
        step();
        step();
        chk("rst_in_ready_x", {31'd0, in_ready}, 32'd1);
        chk("rst_x_valid",    {31'd0, x_valid},  32'd0);
        chk("rst_y_valid",    {31'd0, y_valid},  32'd0);
        chk("rst_x_data",     {16'd0, x_data},   32'h0);
        chk("rst_y_data",     {16'd0, y_data},   32'h0);
        in_sel = 1'b0;
        #1;
        chk("rst_in_ready_y", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_CNT_EN
        chk("rst_x_count", {16'd0, x_count}, 32'd0);
        chk("rst_y_count", {16'd0, y_count}, 32'd0);
`endif

        // Basic routing to X.
        rst_n   = 1'b1;
        in_sel  = 1'b1;
        in_data = 16'hA5A5;
        x_ready = 1'b1;
        step();
        chk("route_x_valid", {31'd0, x_valid}, 32'd1);
        chk("route_x_data",  {16'd0, x_data},  32'hA5A5);
        chk("route_y_quiet", {31'd0, y_valid}, 32'd0);

        // Routing to Y while X drains.
        in_sel  = 1'b0;
        in_data = 16'h1234;
        step();
        chk("route_y_valid",  {31'd0, y_valid}, 32'd1);
        chk("route_y_data",   {16'd0, y_data},  32'h1234);
        chk("x_drained",      {31'd0, x_valid}, 32'd0);
        in_valid = 1'b0;
        step();
        chk("y_hold_stall",   {31'd0, y_valid}, 32'd1);
        y_ready = 1'b1;
        step();
        chk("y_drained",      {31'd0, y_valid}, 32'd0);
        y_ready = 1'b0;

        // Backpressure on X.
        x_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 16'h0001;
        step();
        chk("bp_first_data", {16'd0, x_data}, 32'h0001);
        in_data = 16'h0002;
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_hold_data",  {16'd0, x_data},  32'h0001);
        chk("bp_hold_valid", {31'd0, x_valid}, 32'd1);
        x_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_reload_data",  {16'd0, x_data},  32'h0002);
        chk("bp_reload_valid", {31'd0, x_valid}, 32'd1);

        // Independent stall: X held FULL, Y accepts.
        x_ready = 1'b0;
        in_sel  = 1'b0;
        in_data = 16'hBEEF;
        #1;
        chk("indep_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("indep_y_data",  {16'd0, y_data},  32'hBEEF);
        chk("indep_x_data",  {16'd0, x_data},  32'h0002);
        chk("indep_x_valid", {31'd0, x_valid}, 32'd1);

        // Drain X, drain Y and reload X in one cycle.
        x_ready = 1'b1;
        y_ready = 1'b1;
        in_sel  = 1'b1;
        in_data = 16'h5555;
        step();
        chk("sim_x_data",  {16'd0, x_data},  32'h5555);
        chk("sim_x_valid", {31'd0, x_valid}, 32'd1);
        chk("sim_y_valid", {31'd0, y_valid}, 32'd0);

        // Fill Y too, then reset mid-operation.
        x_ready = 1'b0;
        y_ready = 1'b0;
        in_sel  = 1'b0;
        in_data = 16'h7777;
        step();
        in_valid = 1'b0;
        chk("pre_rst_x_valid", {31'd0, x_valid}, 32'd1);
        chk("pre_rst_y_data",  {16'd0, y_data},  32'h7777);
`ifdef DEMUX_CNT_EN
        chk("pre_rst_x_count", {16'd0, x_count}, 32'd3);
        chk("pre_rst_y_count", {16'd0, y_count}, 32'd2);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x_valid",  {31'd0, x_valid},  32'd0);
        chk("mid_rst_y_valid",  {31'd0, y_valid},  32'd0);
        chk("mid_rst_y_data",   {16'd0, y_data},   32'h0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_x_valid", {31'd0, x_valid}, 32'd0);
        chk("post_rst_y_valid", {31'd0, y_valid}, 32'd0);

        // Back-to-back streaming to X.
        stream_err = 0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        x_ready  = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_data = i[15:0];
            #1;
            if (in_ready !== 1'b1) stream_err++;
            step();
            if (x_valid !== 1'b1 || x_data !== i[15:0]) stream_err++;
        end
        in_valid = 1'b0;
        step();
        chk("stream_errors", stream_err, 32'd0);
        chk("stream_drained", {31'd0, x_valid}, 32'd0);
`ifdef DEMUX_CNT_EN
        chk("stream_x_count", {16'd0, x_count}, 32'd4464);
        chk("stream_y_count", {16'd0, y_count}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux_16bit_reg
`default_nettype wire
